// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : Parametrised chain of STAGES pipeline registers (IF/ID, ID/EX,
//               EX/MEM, MEM/WB by default). Each stage carries a valid bit and
//               a DATA_W payload. Supports per-stage stall with bubble
//               collapsing, per-stage flush (redirect) and saturating
//               retire/bubble performance counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W  payload width per stage
//   STAGES  number of pipeline registers (legal range 2..8)
//   CNT_W   width of each performance counter
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     IF presents a bundle
//   in_data      bundle from IF
//   in_ready     stage 0 accepts this cycle (combinational)
//   stall_req    bit k: consumer of stage k cannot take it this cycle
//   flush_req    bit k: kill stages 0..k at this edge
//   stage_valid  registered valid bit per stage
//   stage_data   registered payloads, stage k at [k*DATA_W +: DATA_W]
//   out_valid    valid bit of the last stage
//   out_data     payload of the last stage
//   retire_cnt   bundles that left the last stage (saturating)
//   bubble_cnt   cycles with the last stage invalid (saturating)
// ============================================================================
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic [STAGES-1:0]        flush_req,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [STAGES-1:0] w_valid;
  logic [DATA_W-1:0] w_data [STAGES];
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_kill;

  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_retire;

  // --------------------------------------------------------------------------
  // Hold chain, evaluated from the WB end backwards. An invalid stage never
  // holds, which is what lets stages behind a bubble keep advancing.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hold = '0;
    w_hold[STAGES-1] = w_valid[STAGES-1] & stall_req[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_hold[k] = w_valid[k] & (stall_req[k] | w_hold[k+1]);
    end
  end

  // --------------------------------------------------------------------------
  // Kill mask: a flush at stage k kills everything at or behind k, so
  // kill[j] is the OR of flush_req[STAGES-1:j]. kill[0] doubles as the
  // source kill for the incoming bundle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_kill = '0;
    w_kill[STAGES-1] = flush_req[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_kill[k] = flush_req[k] | w_kill[k+1];
    end
  end

  // in_ready deliberately ignores flush: an input taken during a flush is
  // consumed and dropped via the source kill.
  assign in_ready = ~w_hold[0];

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    logic              r_v;
    logic [DATA_W-1:0] r_d;
    logic              w_src_valid;
    logic [DATA_W-1:0] w_src_data;
    logic              w_src_hold;
    logic              w_src_kill;

    if (j == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = in_data;
      assign w_src_hold  = 1'b0;
      assign w_src_kill  = w_kill[0];
    end else begin : g_body
      assign w_src_valid = w_valid[j-1];
      assign w_src_data  = w_data[j-1];
      assign w_src_hold  = w_hold[j-1];
      assign w_src_kill  = w_kill[j-1];
    end

    // Kill only clears the valid bit; the payload follows the normal
    // hold/load rule since it is meaningless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        if (!w_hold[j]) begin
          r_d <= w_src_data;
        end
        if (w_kill[j]) begin
          r_v <= 1'b0;
        end else if (!w_hold[j]) begin
          r_v <= w_src_valid & ~w_src_hold & ~w_src_kill;
        end
      end
    end

    assign w_valid[j]                        = r_v;
    assign w_data[j]                         = r_d;
    assign stage_data[j*DATA_W +: DATA_W]    = r_d;
  end

  assign stage_valid = w_valid;
  assign out_valid   = w_valid[STAGES-1];
  assign out_data    = w_data[STAGES-1];

  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  assign w_retire = w_valid[STAGES-1] & ~stall_req[STAGES-1] & ~flush_req[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_retire && (r_retire_cnt != c_cnt_max)) begin
        r_retire_cnt <= r_retire_cnt + c_cnt_one;
      end
      if (!w_valid[STAGES-1] && (r_bubble_cnt != c_cnt_max)) begin
        r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Directed self-checking bench for pipe_stage_chain
//               (STAGES=4, DATA_W=32, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

  localparam int DATA_W = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stall_req;
  logic [STAGES-1:0]        flush_req;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         retire_cnt;
  logic [CNT_W-1:0]         bubble_cnt;

  int n_tests;
  int n_fail;

  pipe_stage_chain #(
    .DATA_W (DATA_W),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .retire_cnt  (retire_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = '0;
    flush_req = '0;
    rst_n     = 1'b0;
    #1;
    tick();
    rst_n     = 1'b1;
  endtask

  // Presents four back-to-back bundles, then drops in_valid.
  task automatic fill4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    in_valid = 1'b1; in_data = a; tick();
    in_data  = b; tick();
    in_data  = c; tick();
    in_data  = d; tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = '0;
    flush_req = '0;

    // ---------------- power-on reset state ----------------
    #3;
    chk("por_valid",  stage_valid, 4'b0000);
    chk("por_ready",  in_ready,    1'b1);
    chk("por_retire", retire_cnt,  4'd0);
    chk("por_bubble", bubble_cnt,  4'd0);
    tick();
    rst_n = 1'b1;

    // ---------------- asynchronous reset while full ----------------
    fill4(32'h1, 32'h2, 32'h3, 32'h4);
    chk("fill_valid", stage_valid, 4'b1111);
    chk("fill_data",  stage_data,  {32'h1, 32'h2, 32'h3, 32'h4});
    chk("fill_bubble", bubble_cnt, 4'd4);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  stage_valid, 4'b0000);
    chk("arst_data",   stage_data,  128'h0);
    chk("arst_ready",  in_ready,    1'b1);
    chk("arst_retire", retire_cnt,  4'd0);
    chk("arst_bubble", bubble_cnt,  4'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // ---------------- streaming ----------------
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data  = 32'h22; tick();
    in_data  = 32'h33; tick();
    in_valid = 1'b0;
    tick();
    chk("strm_v0", out_valid, 1'b1);
    chk("strm_d0", out_data,  32'h11);
    tick();
    chk("strm_d1", out_data,  32'h22);
    tick();
    chk("strm_d2", out_data,  32'h33);
    chk("strm_v2", out_valid, 1'b1);
    tick();
    chk("strm_end_v",  out_valid,  1'b0);
    chk("strm_retire", retire_cnt, 4'd3);

    // ---------------- full-chain stall ----------------
    do_reset();
    fill4(32'h1, 32'h2, 32'h3, 32'h4);
    in_valid = 1'b1; in_data = 32'h5; stall_req = 4'b1000;
    #1;
    chk("stl_ready0", in_ready, 1'b0);
    tick();
    chk("stl_data0",  stage_data,  {32'h1, 32'h2, 32'h3, 32'h4});
    chk("stl_valid0", stage_valid, 4'b1111);
    chk("stl_ready1", in_ready,    1'b0);
    tick();
    chk("stl_data1",   stage_data, {32'h1, 32'h2, 32'h3, 32'h4});
    chk("stl_retire0", retire_cnt, 4'd0);
    stall_req = 4'b0000;
    #1;
    chk("stl_ready2", in_ready, 1'b1);
    tick();
    chk("stl_data2",   stage_data,  {32'h2, 32'h3, 32'h4, 32'h5});
    chk("stl_valid2",  stage_valid, 4'b1111);
    chk("stl_retire1", retire_cnt,  4'd1);
    in_valid = 1'b0;
    tick();
    chk("stl_out3", out_data, 32'h3);
    tick();
    chk("stl_out4", out_data, 32'h4);
    tick();
    chk("stl_out5", out_data, 32'h5);
    tick();
    chk("stl_drain_v",  out_valid,  1'b0);
    chk("stl_retire5",  retire_cnt, 4'd5);

    // ---------------- stall with bubble collapsing ----------------
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data  = 32'hB; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 32'hD; tick();
    chk("col_valid0", stage_valid, 4'b1101);
    in_data = 32'hE; stall_req = 4'b1000;
    #1;
    chk("col_ready0", in_ready, 1'b1);
    tick();
    chk("col_valid1", stage_valid, 4'b1111);
    chk("col_data1",  stage_data,  {32'hA, 32'hB, 32'hD, 32'hE});
    chk("col_ready1", in_ready,    1'b0);
    tick();
    chk("col_data2",  stage_data,  {32'hA, 32'hB, 32'hD, 32'hE});
    stall_req = 4'b0000; in_valid = 1'b0;
    tick();
    chk("col_out",    out_data,    32'hB);
    chk("col_retire", retire_cnt,  4'd1);

    // ---------------- flush at stage 1 ----------------
    do_reset();
    fill4(32'hA, 32'hB, 32'hC, 32'hD);
    in_valid = 1'b1; in_data = 32'hE; flush_req = 4'b0010;
    #1;
    chk("fl_ready", in_ready, 1'b1);
    tick();
    chk("fl_valid",  stage_valid, 4'b1000);
    chk("fl_out",    out_data,    32'hB);
    chk("fl_retire", retire_cnt,  4'd1);
    flush_req = 4'b0000; in_valid = 1'b0;
    tick();
    chk("fl_valid2",  stage_valid, 4'b0000);
    chk("fl_retire2", retire_cnt,  4'd2);

    // ---------------- kill beats hold ----------------
    do_reset();
    fill4(32'hA, 32'hB, 32'hC, 32'hD);
    stall_req = 4'b0100; flush_req = 4'b0100;
    #1;
    chk("kh_ready", in_ready, 1'b0);
    tick();
    chk("kh_valid",  stage_valid, 4'b0000);
    chk("kh_retire", retire_cnt,  4'd1);
    stall_req = 4'b0000; flush_req = 4'b0000;

    // ---------------- bubble counter saturation ----------------
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_b14", bubble_cnt, 4'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_b20", bubble_cnt, 4'd15);
    tick();
    chk("sat_hold",   bubble_cnt, 4'd15);
    chk("sat_retire", retire_cnt, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of pipeline registers that turns the single-cycle IF/ID/EX/MEM/WB datapath into a real pipeline. It holds STAGES inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB by default), each with a valid bit. It supports per-stage stall with bubble collapsing, per-stage flush for branch/jump redirect, and retire/bubble performance counters. Instruction/control bundles enter from the IF side and leave at the WB side.

## Interface
- DATA_W, 32: width of the payload bundle carried per stage.
- STAGES, 4: number of pipeline registers; legal range 2..8.
- CNT_W, 16: width of each performance counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  IF presents a bundle.
- in_data  in  DATA_W  bundle from IF.
- in_ready  out  1  stage 0 accepts this cycle; combinational from stall_req and stage valids.
- stall_req  in  STAGES  bit k: stage k's consumer cannot take stage k this cycle.
- flush_req  in  STAGES  bit k: kill the contents of stages 0..k at this edge.
- stage_valid  out  STAGES  registered valid bit per stage.
- stage_data  out  STAGES*DATA_W  registered payloads, stage k at [k*DATA_W +: DATA_W].
- out_valid  out  1  equal to stage_valid[STAGES-1].
- out_data  out  DATA_W  equal to payload of stage STAGES-1.
- retire_cnt  out  CNT_W  bundles that left the last stage.
- bubble_cnt  out  CNT_W  cycles with the last stage invalid.

## Operation
- Hold chain (combinational):
  - hold[S-1] = valid[S-1] & stall_req[S-1]
  - hold[k] = valid[k] & (stall_req[k] | hold[k+1])
  - An invalid stage never holds, so bubbles collapse: a stage behind a bubble keeps advancing while stages further ahead are stalled.
- in_ready = ~hold[0]. A handshake completes when in_valid & in_ready.
- Kill mask: kill[j] = |flush_req[S-1:j]. Source kill for the input: kill_in = |flush_req.
- Per-stage update at each edge (j = 0..S-1; source of stage 0 is in_valid/in_data with kill_in):
  - If kill[j]: valid[j] <= 0. Data updates as if not killed (held if hold[j], else loaded).
  - Else if hold[j]: valid and data unchanged.
  - Else load from the source. valid[j] <= src_valid & ~src_hold & ~src_kill. Data loads src data unconditionally.
- Kill beats hold on the same stage. The whole valid/data update is a single rule set, not a sequence of steps.
- An input accepted in a cycle with any flush_req bit set is consumed and discarded. in_ready is not masked by flush.
- Payload is meaningful only when the matching valid bit is 1.
- Counters:
  - retire_cnt increments when out_valid & ~stall_req[S-1] & ~flush_req[S-1].
  - bubble_cnt increments on every cycle with out_valid = 0.
  - Both counters saturate at all-ones and do not wrap.
- Reset (asynchronous, any time including mid-stall or mid-flush): all valid bits 0, all payloads 0, both counters 0. Consequently in_ready = 1 during and after reset.

## Timing
- No stalls: a bundle accepted at edge t is in stage k after edge t+k. out_valid is asserted STAGES cycles after in_valid is first sampled. Throughput is 1 bundle per cycle.
- Stall: a stage whose hold is asserted keeps its value across the edge. in_ready falls in the same cycle that hold[0] rises, with no registered delay.
- Flush takes effect at the edge of the cycle in which it is asserted. Stage k+1 receives a bubble at that edge.
- Combinational paths exist from stall_req and flush_req to in_ready and to the next-state logic only. All other outputs are registered.

## Test plan
- Reset: fill all 4 stages, pull rst_n low between clock edges. Required: stage_valid = 0, counters = 0, in_ready = 1 immediately. After release the chain refills normally.
- Streaming (STAGES=4): present 0x11, 0x22, 0x33 on consecutive cycles. Required: out_data shows 0x11, 0x22, 0x33 on 3 consecutive cycles, the first 4 cycles after 0x11 was presented. retire_cnt = 3 afterwards.
- Stall and collapse:
  - Full chain with stall_req[3] = 1 for 2 cycles. Required: in_ready = 0 both cycles, no loss or duplication.
  - Repeat with stage 1 invalid. Required: stage 0's entry moves into stage 1 while stage 3 is stalled, and in_ready stays 1 for one more accept.
- Flush: stages 3..0 hold A, B, C, D, in_data = E, flush_req = 4'b0010. Required after the edge: stage3 = B valid, stage2 invalid, stages 1 and 0 invalid, E discarded, retire_cnt +1 for A.
- Kill vs hold: stall_req[2] = 1 and flush_req[2] = 1 together. Required: stages 0..2 invalid after the edge, stage 3 retires normally.
- Saturation (CNT_W=4): run 20 idle cycles after reset. Required: bubble_cnt = 15 and stays at 15.
